// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    localparam int CNT_W = 4;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide unit: 64-bit {hi,lo} result from latched
// operands, plus a flag for a divide with a zero divisor.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  op_e         op,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        is_signed_div;
    logic [31:0] b_safe;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    always_comb begin
        is_signed_div = (op == OP_DIV);
        div_zero      = ((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0);
        // Substitute 1 for a zero divisor so the divider never produces X.
        b_safe        = (b == 32'd0) ? 32'd1 : b;

        // Signed divide works on magnitudes; -2^31 keeps magnitude 0x80000000,
        // which makes 0x80000000 / -1 wrap to 0x80000000 naturally.
        dvd_mag = (is_signed_div && a[31])      ? (32'd0 - a)      : a;
        dvs_mag = (is_signed_div && b_safe[31]) ? (32'd0 - b_safe) : b_safe;
        quo_mag = dvd_mag / dvs_mag;
        rem_mag = dvd_mag % dvs_mag;
        quo     = (is_signed_div && (a[31] ^ b_safe[31])) ? (32'd0 - quo_mag) : quo_mag;
        rem     = (is_signed_div && a[31]) ? (32'd0 - rem_mag) : rem_mag;

        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        case (op)
            OP_MULT:          result = prod_s;
            OP_MULTU:         result = prod_u;
            OP_DIV, OP_DIVU:  result = {rem, quo};
            default:          result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle HI/LO sequencer: accepts mult/div requests, holds busy for the
// configured latency, then commits the result to HI/LO with a done pulse.
module md_seq
    import md_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opt,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_reg;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    op_e                op_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic               done_reg;

    logic               accept;
    logic               finish;
    logic               mt_hi;
    logic               mt_lo;
    logic [CNT_W-1:0]   lat_load;
    logic [63:0]        result;
    logic               div_zero;

    md_arith u_arith (
        .a        (a_reg),
        .b        (b_reg),
        .op       (op_reg),
        .result   (result),
        .div_zero (div_zero)
    );

    // opt[1] distinguishes the divide codes from the multiply codes.
    assign lat_load = opt[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op_e'(opt))
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            accept     = 1'b1;
                            state_next = ST_BUSY;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_BUSY);
        done = done_reg;
        hi   = hi_reg;
        lo   = lo_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= OP_MULT;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
            if (accept) begin
                a_reg   <= v1;
                b_reg   <= v2;
                op_reg  <= op_e'(opt);
                cnt_reg <= lat_load;
            end else if (state_reg == ST_BUSY) begin
                cnt_reg <= cancel ? '0 : cnt_reg - CNT_W'(1);
            end
            if (finish && !div_zero) begin
                hi_reg <= result[63:32];
                lo_reg <= result[31:0];
            end
            if (mt_hi) begin
                hi_reg <= v1;
            end
            if (mt_lo) begin
                lo_reg <= v1;
            end
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Bench for md_seq: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed HI/LO values.
`timescale 1ns/1ps
module tb_md_seq;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opt = 3'd0;
    logic [31:0] v1 = 32'd0;
    logic [31:0] v2 = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    md_seq #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opt    (opt),
        .v1     (v1),
        .v2     (v2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: interval k follows clock edge k; an op accepted at
    // edge t is busy in intervals t..t+LAT-1 and commits at edge t+LAT.
    int          cyc = 0;
    int          m_acc = 0;
    int          m_lat = 0;
    int          m_done_at = -1;
    bit          m_inflight = 0;
    bit          p_ok = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] p_hi = 0;
    logic [31:0] p_lo = 0;
    bit          model_on = 0;

    initial begin
        longint      sd, sv, q, r;
        logic [63:0] pu;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_hi = 0; m_lo = 0; m_inflight = 0; m_done_at = -1;
            end else begin
                cyc++;
                if (m_inflight) begin
                    if (cancel) begin
                        m_inflight = 0;
                    end else if (cyc == m_acc + m_lat) begin
                        if (p_ok) begin
                            m_hi = p_hi; m_lo = p_lo;
                        end
                        m_done_at  = cyc;
                        m_inflight = 0;
                    end
                end else if (start && !cancel) begin
                    if (opt <= 3'd3) begin
                        m_inflight = 1;
                        m_acc = cyc;
                        m_lat = (opt >= 3'd2) ? DIV_LAT : MULT_LAT;
                        p_ok  = 1;
                    end
                    case (opt)
                        3'd0: begin
                            pu = 64'(longint'($signed(v1)) * longint'($signed(v2)));
                            p_hi = pu[63:32]; p_lo = pu[31:0];
                        end
                        3'd1: begin
                            pu = {32'd0, v1} * {32'd0, v2};
                            p_hi = pu[63:32]; p_lo = pu[31:0];
                        end
                        3'd2, 3'd3: begin
                            if (v2 == 32'd0) begin
                                p_ok = 0;
                            end else begin
                                sd = (opt == 3'd2) ? longint'($signed(v1)) : longint'({32'd0, v1});
                                sv = (opt == 3'd2) ? longint'($signed(v2)) : longint'({32'd0, v2});
                                q = sd / sv;
                                r = sd % sv;
                                p_lo = q[31:0]; p_hi = r[31:0];
                            end
                        end
                        3'd4: m_hi = v1;
                        3'd5: m_lo = v1;
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on && !reset) begin
                check("model_busy", {31'd0, busy}, {31'd0, m_inflight});
                check("model_done", {31'd0, done}, {31'd0, (cyc == m_done_at)});
                check("model_hi", hi, m_hi);
                check("model_lo", lo, m_lo);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; opt = o; v1 = a; v2 = b;
        @(posedge clk); #1;
        start = 1'b0; v1 = $urandom; v2 = $urandom;
    endtask

    task automatic wait_op(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb;
        bit seen;
        issue(o, a, b);
        wait_op(nb, seen);
        check({name, "_done"}, {31'd0, seen}, 32'd1);
        check({name, "_busy_cycles"}, nb, lat);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        $display("op %s v1=0x%08h v2=0x%08h busy=%0d hi=0x%08h lo=0x%08h", name, a, b, nb, hi, lo);
    endtask

    initial begin
        int  nb;
        bit  seen;
        bit  any_done;

        #2;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_on = 1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu", 3'd3, 32'd17, 32'd5, DIV_LAT, 32'd2, 32'd3);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_zero", 3'd2, 32'd99, 32'd0, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd4, 32'h1234, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        $display("op mthi v1=0x00001234 hi=0x%08h lo=0x%08h", hi, lo);

        // A second start during BUSY must not disturb the running multiply.
        issue(3'd0, 32'd5, 32'd6);
        @(posedge clk); #1;
        start = 1'b1; opt = 3'd0; v1 = 32'd2; v2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_op(nb, seen);
        check("busy_start_done", {31'd0, seen}, 32'd1);
        check("busy_start_hi", hi, 32'd0);
        check("busy_start_lo", lo, 32'd30);
        $display("op mult 5*6 with ignored 2*2 hi=0x%08h lo=0x%08h", hi, lo);

        issue(3'd5, 32'hABCD, 32'd0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'hABCD);
        $display("op mtlo v1=0x0000abcd hi=0x%08h lo=0x%08h", hi, lo);

        // cancel together with start suppresses even mthi
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1; opt = 3'd4; v1 = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check("cancel_mthi_hi", hi, 32'd0);
        $display("op mthi+cancel hi=0x%08h lo=0x%08h", hi, lo);

        issue(3'd6, 32'h5555, 32'h7);
        @(negedge clk);
        check("reserved_busy", {31'd0, busy}, 32'd0);
        check("reserved_lo", lo, 32'hABCD);
        $display("op reserved hi=0x%08h lo=0x%08h", hi, lo);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);

        // Cancel in the third busy cycle of a multu.
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", {31'd0, busy}, 32'd0);
        any_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) any_done = 1;
        end
        check("cancel_no_done", {31'd0, any_done}, 32'd0);
        check("cancel_hi", hi, 32'd0);
        check("cancel_lo", lo, 32'h8000_0000);
        $display("op multu cancelled hi=0x%08h lo=0x%08h", hi, lo);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'hFFFF_FFFE, 32'h0000_0001);

        // Asynchronous reset in the middle of a divide.
        issue(3'd2, 32'd100, 32'd7);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        $display("op div aborted by reset hi=0x%08h lo=0x%08h", hi, lo);

        run_op("mult_after_reset", 3'd0, 32'd3, 32'd4, MULT_LAT, 32'd0, 32'd12);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: multiply latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter DIV_LAT, default 10: divide latency in cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled at the clk edge.
REQ-006 SHALL have port opt, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 reserved.
REQ-007 SHALL have port v1, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 SHALL have port v2, input, 32 bits: rt operand (divisor / multiplier).
REQ-009 SHALL have port cancel, input, 1 bit: abort of the in-flight or same-cycle operation, issued on pipeline flush.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse in the first cycle that committed HI/LO results are visible.
REQ-012 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-013 SHALL have port lo, output, 32 bits: architectural LO register.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and BUSY; hi and lo are driven directly from registers.
REQ-015 IDLE, start=1, cancel=0, opt in 000..011: SHALL latch v1, v2 and opt, load counter with MULT_LAT or DIV_LAT, and go to BUSY.
REQ-016 SHALL hold busy=1 for exactly LAT cycles, i.e. cycles t+1..t+LAT, where t is the accepting edge.
REQ-017 On the edge ending the last BUSY cycle, SHALL write HI/LO, return to IDLE and drive done=1 in cycle t+LAT+1 only.
REQ-018 mult/multu SHALL produce the 64-bit signed/unsigned product: {hi,lo} = product.
REQ-019 div/divu SHALL set lo = quotient, truncated toward zero, and hi = remainder, which takes the sign of the dividend.
REQ-020 Divisor of zero SHALL leave hi and lo unchanged while preserving the full busy timing and the done pulse.
REQ-021 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 IDLE, start=1, opt=100 or 101: SHALL write v1 to hi or lo at that edge, with no busy and no done.
REQ-023 start while BUSY SHALL be ignored; the upstream stall prevents it, and the block must not corrupt state.
REQ-024 Reserved opt with start=1 SHALL be ignored.
REQ-025 cancel=1 while BUSY SHALL return the FSM to IDLE at the next edge, with hi/lo unchanged and no done.
REQ-026 cancel=1 together with start=1 in IDLE SHALL suppress the request, including mthi/mtlo.
REQ-027 Operands SHALL be taken only from the latched copies; v1/v2 changes during BUSY SHALL have no effect.

Reset
REQ-028 reset SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and clear the latched operands.
REQ-029 Reset asserted mid-operation SHALL discard that operation; the first edge after deassertion behaves as IDLE.

Structure
REQ-030 The shared package md_pkg SHALL hold the opt encoding as an enum, the FSM state enum, and the default MULT_LAT/DIV_LAT constants.
REQ-031 md_seq SHALL contain exactly one sub-module: md_arith, a combinational unit taking latched operands and opt and returning a 64-bit {hi,lo} result plus a div-by-zero flag.
REQ-032 Counter width SHALL be 4 bits.

Verification
REQ-033 Scenario: mult, v1=0xFFFFFFFE (-2), v2=3 -> busy for cycles 1..5; cycle 6 shows hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1.
REQ-034 Scenario: divu, v1=17, v2=5 -> busy 10 cycles; then lo=3, hi=2, done pulses once.
REQ-035 Scenario: div, v1=-7, v2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then div by v2=0 -> hi/lo unchanged after 10 busy cycles.
REQ-036 Scenario: mthi with v1=0x1234 -> hi=0x1234 next cycle, busy stays 0; a second start (mult 2*2) issued during BUSY is ignored.
REQ-037 Scenario: cancel in BUSY cycle 3 of a multu -> busy=0 next cycle, hi/lo keep prior values, done never asserts.
REQ-038 Scenario: reset pulse mid-div asserted between edges -> outputs 0 immediately; a following mult 3*4 yields lo=12.
